// File: rtl/arrhythmia_feature_loader.sv
// Streams one patient sample of NUM_FEATURES bytes, captures the five features the decision
// tree consumes, holds them for the combinational tree and hands the class out on valid/ready.
module arrhythmia_feature_loader #(
    parameter int NUM_FEATURES = 279,
    parameter int IDX_A        = 13,
    parameter int IDX_B        = 27,
    parameter int IDX_C        = 235,
    parameter int IDX_D        = 264,
    parameter int IDX_E        = 278
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic [7:0]  x13,
    output logic [7:0]  x27,
    output logic [7:0]  x235,
    output logic [7:0]  x264,
    output logic [7:0]  x278,
    input  logic [4:0]  tree_class,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [4:0]  m_class,
    output logic        frame_err,
    output logic [15:0] sample_cnt,
    output logic [1:0]  o_dbg_state
);

    // Handshakes: a transfer happens on any rising edge where valid and ready are both high;
    // a producer holds valid and its payload until that edge, and valid never drops without it.

    localparam int IDX_W = $clog2(NUM_FEATURES);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);
    localparam logic [IDX_W-1:0] K_A      = IDX_W'(IDX_A);
    localparam logic [IDX_W-1:0] K_B      = IDX_W'(IDX_B);
    localparam logic [IDX_W-1:0] K_C      = IDX_W'(IDX_C);
    localparam logic [IDX_W-1:0] K_D      = IDX_W'(IDX_D);
    localparam logic [IDX_W-1:0] K_E      = IDX_W'(IDX_E);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_EVAL    = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_sh_a, r_sh_b, r_sh_c, r_sh_d, r_sh_e;
    logic [7:0]       r_x_a, r_x_b, r_x_c, r_x_d, r_x_e;
    logic             r_m_valid;
    logic [4:0]       r_m_class;
    logic             r_frame_err;
    logic [15:0]      r_sample_cnt;

    logic             w_accept;
    logic             w_collect_beat;
    logic             w_at_end;
    logic [7:0]       w_sh_a_nxt, w_sh_b_nxt, w_sh_c_nxt, w_sh_d_nxt, w_sh_e_nxt;

    // Ready is a pure state decode so it reads 1 while reset holds the FSM in COLLECT.
    assign s_ready        = (r_state == ST_COLLECT) || (r_state == ST_DRAIN);
    assign w_accept       = s_valid & s_ready;
    assign w_collect_beat = w_accept && (r_state == ST_COLLECT);
    assign w_at_end       = (r_idx == LAST_IDX);

    // Next shadow values include the current beat, so the final beat can itself be a feature.
    assign w_sh_a_nxt = (w_collect_beat && r_idx == K_A) ? s_data : r_sh_a;
    assign w_sh_b_nxt = (w_collect_beat && r_idx == K_B) ? s_data : r_sh_b;
    assign w_sh_c_nxt = (w_collect_beat && r_idx == K_C) ? s_data : r_sh_c;
    assign w_sh_d_nxt = (w_collect_beat && r_idx == K_D) ? s_data : r_sh_d;
    assign w_sh_e_nxt = (w_collect_beat && r_idx == K_E) ? s_data : r_sh_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_a <= '0;
            r_sh_b <= '0;
            r_sh_c <= '0;
            r_sh_d <= '0;
            r_sh_e <= '0;
        end else begin
            r_sh_a <= w_sh_a_nxt;
            r_sh_b <= w_sh_b_nxt;
            r_sh_c <= w_sh_c_nxt;
            r_sh_d <= w_sh_d_nxt;
            r_sh_e <= w_sh_e_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_COLLECT;
            r_idx        <= '0;
            r_x_a        <= '0;
            r_x_b        <= '0;
            r_x_c        <= '0;
            r_x_d        <= '0;
            r_x_e        <= '0;
            r_m_valid    <= 1'b0;
            r_m_class    <= '0;
            r_frame_err  <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_COLLECT: begin
                    if (w_accept) begin
                        if (s_last) begin
                            r_idx <= '0;
                            if (w_at_end) begin
                                r_x_a   <= w_sh_a_nxt;
                                r_x_b   <= w_sh_b_nxt;
                                r_x_c   <= w_sh_c_nxt;
                                r_x_d   <= w_sh_d_nxt;
                                r_x_e   <= w_sh_e_nxt;
                                r_state <= ST_EVAL;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end else if (w_at_end) begin
                            // Over-long frame: flag once, then swallow the rest in DRAIN.
                            r_frame_err <= 1'b1;
                            r_idx       <= '0;
                            r_state     <= ST_DRAIN;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_accept && s_last) begin
                        r_state <= ST_COLLECT;
                    end
                end
                ST_EVAL: begin
                    r_m_class <= tree_class;
                    r_m_valid <= 1'b1;
                    r_state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        r_m_valid    <= 1'b0;
                        r_sample_cnt <= r_sample_cnt + 16'd1;
                        r_state      <= ST_COLLECT;
                    end
                end
                default: begin
                    r_state <= ST_COLLECT;
                end
            endcase
        end
    end

    assign x13         = r_x_a;
    assign x27         = r_x_b;
    assign x235        = r_x_c;
    assign x264        = r_x_d;
    assign x278        = r_x_e;
    assign m_valid     = r_m_valid;
    assign m_class     = r_m_class;
    assign frame_err   = r_frame_err;
    assign sample_cnt  = r_sample_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_arrhythmia_feature_loader.sv
// Directed bench for arrhythmia_feature_loader: good, short, long, reset-interrupted and
// gapped frames, with byte i of a frame equal to (i + seed) mod 256.
module tb_arrhythmia_feature_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [7:0]  x13, x27, x235, x264, x278;
    logic [4:0]  tree_class;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_class;
    logic        frame_err;
    logic [15:0] sample_cnt;
    logic [1:0]  dbg_state;

    int checks = 0;
    int passes = 0;
    int err_pulses = 0;
    logic [4:0] exp_q[$];

    arrhythmia_feature_loader dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .x13(x13), .x27(x27), .x235(x235), .x264(x264), .x278(x278),
        .tree_class(tree_class),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
        .frame_err(frame_err), .sample_cnt(sample_cnt), .o_dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && frame_err) err_pulses++;

    function automatic logic [7:0] fb(input int i, input int seed);
        return 8'((i + seed) & 255);
    endfunction

    // drivers
    task automatic send_beat(input logic [7:0] d, input logic last, input bit gap);
        int n;
        if (gap) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b1; s_data = d; s_last = last;
        n = 0;
        while (!s_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) begin
            checks++;
            $display("FAIL beat_timeout s_ready stayed %0d, required 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input int nbeats, input int seed, input bit gaps);
        for (int i = 0; i < nbeats; i++) send_beat(fb(i, seed), (i == nbeats - 1), gaps);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        tree_class = '0; m_ready = 1'b0;
        #12;
        checks++; if (s_ready !== 1'b1) $display("FAIL rst_s_ready got %0d need 1", s_ready); else passes++;
        checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %0d need 0", m_valid); else passes++;
        checks++; if ({x13, x27, x235, x264, x278} !== 40'd0) $display("FAIL rst_x got %h need 0", {x13, x27, x235, x264, x278}); else passes++;
        checks++; if (sample_cnt !== 16'd0 || frame_err !== 1'b0 || m_class !== 5'd0)
            $display("FAIL rst_misc got cnt=%0d err=%0d cls=%0d need 0", sample_cnt, frame_err, m_class); else passes++;
        @(negedge clk); rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        tree_class = 5'd9; m_ready = 1'b1;
        send_frame(279, 0, 0);
        checks++; if (x13 !== 8'h0D) $display("FAIL t1_x13 got %h need 0d", x13); else passes++;
        checks++; if (x278 !== 8'h16) $display("FAIL t1_x278 got %h need 16", x278); else passes++;
        checks++; if (m_valid !== 1'b0 || s_ready !== 1'b0) $display("FAIL t1_eval got mv=%0d sr=%0d need 0 0", m_valid, s_ready); else passes++;
        step();
        checks++; if (m_valid !== 1'b1) $display("FAIL t1_latency m_valid got %0d need 1", m_valid); else passes++;
        checks++; if (m_class !== 5'd9) $display("FAIL t1_class got %0d need 9", m_class); else passes++;
        step();
        checks++; if (m_valid !== 1'b0 || sample_cnt !== 16'd1) $display("FAIL t1_accept got mv=%0d cnt=%0d need 0 1", m_valid, sample_cnt); else passes++;
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0; tree_class = 5'd17;
        send_frame(279, 50, 0);
        step();
        checks++; if (m_valid !== 1'b1 || m_class !== 5'd17) $display("FAIL t2_valid got mv=%0d cls=%0d need 1 17", m_valid, m_class); else passes++;
        tree_class = 5'd3;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (m_valid !== 1'b1 || m_class !== 5'd17 || s_ready !== 1'b0 || x13 !== fb(13, 50) || x264 !== fb(264, 50))
                $display("FAIL t2_hold cyc%0d got mv=%0d cls=%0d sr=%0d x13=%h x264=%h", c, m_valid, m_class, s_ready, x13, x264);
            else passes++;
        end
        m_ready = 1'b1;
        step();
        checks++; if (m_valid !== 1'b0 || sample_cnt !== 16'd2) $display("FAIL t2_accept got mv=%0d cnt=%0d need 0 2", m_valid, sample_cnt); else passes++;
    endtask

    task automatic test_short_frame();
        send_frame(100, 7, 0);
        checks++; if (frame_err !== 1'b1) $display("FAIL t3_err got %0d need 1", frame_err); else passes++;
        checks++; if (x13 !== fb(13, 50) || x27 !== fb(27, 50)) $display("FAIL t3_x_kept got %h %h need %h %h", x13, x27, fb(13, 50), fb(27, 50)); else passes++;
        step();
        checks++; if (frame_err !== 1'b0 || m_valid !== 1'b0) $display("FAIL t3_pulse got err=%0d mv=%0d need 0 0", frame_err, m_valid); else passes++;
        tree_class = 5'd4;
        send_frame(279, 3, 0);
        checks++; if (x13 !== fb(13, 3) || x264 !== fb(264, 3)) $display("FAIL t3_next_x got %h %h need %h %h", x13, x264, fb(13, 3), fb(264, 3)); else passes++;
        step();
        checks++; if (m_valid !== 1'b1 || m_class !== 5'd4) $display("FAIL t3_next_cls got mv=%0d cls=%0d need 1 4", m_valid, m_class); else passes++;
        step();
        checks++; if (sample_cnt !== 16'd3) $display("FAIL t3_cnt got %0d need 3", sample_cnt); else passes++;
    endtask

    task automatic test_long_frame();
        for (int i = 0; i < 279; i++) send_beat(fb(i, 100), 1'b0, 0);
        checks++; if (frame_err !== 1'b1 || dbg_state !== 2'd3) $display("FAIL t4_err got err=%0d st=%0d need 1 3", frame_err, dbg_state); else passes++;
        for (int i = 279; i < 285; i++) begin
            send_beat(fb(i, 100), (i == 284), 0);
            checks++; if (frame_err !== 1'b0) $display("FAIL t4_drain_err beat%0d got %0d need 0", i, frame_err); else passes++;
        end
        checks++; if (dbg_state !== 2'd0 || x13 !== fb(13, 3)) $display("FAIL t4_after got st=%0d x13=%h need 0 %h", dbg_state, x13, fb(13, 3)); else passes++;
        tree_class = 5'd12;
        send_frame(279, 200, 0);
        checks++; if (x13 !== 8'hD5) $display("FAIL t4_x13 got %h need d5", x13); else passes++;
        step();
        checks++; if (m_valid !== 1'b1 || m_class !== 5'd12) $display("FAIL t4_cls got mv=%0d cls=%0d need 1 12", m_valid, m_class); else passes++;
        step();
        checks++; if (sample_cnt !== 16'd4) $display("FAIL t4_cnt got %0d need 4", sample_cnt); else passes++;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 150; i++) send_beat(fb(i, 9), 1'b0, 0);
        rst_n = 1'b0;
        #1;
        checks++; if ({x13, x27, x235, x264, x278} !== 40'd0) $display("FAIL t5_x got %h need 0", {x13, x27, x235, x264, x278}); else passes++;
        checks++; if (sample_cnt !== 16'd0 || m_valid !== 1'b0 || m_class !== 5'd0 || frame_err !== 1'b0)
            $display("FAIL t5_out got cnt=%0d mv=%0d cls=%0d err=%0d need 0", sample_cnt, m_valid, m_class, frame_err); else passes++;
        checks++; if (s_ready !== 1'b1) $display("FAIL t5_s_ready got %0d need 1", s_ready); else passes++;
        @(negedge clk); rst_n = 1'b1;
        step();
        tree_class = 5'd21;
        send_frame(279, 1, 0);
        checks++; if (x235 !== fb(235, 1) || x13 !== fb(13, 1)) $display("FAIL t5_x_after got %h %h need %h %h", x235, x13, fb(235, 1), fb(13, 1)); else passes++;
        step();
        checks++; if (m_valid !== 1'b1 || m_class !== 5'd21) $display("FAIL t5_cls got mv=%0d cls=%0d need 1 21", m_valid, m_class); else passes++;
        step();
        checks++; if (sample_cnt !== 16'd1) $display("FAIL t5_cnt got %0d need 1", sample_cnt); else passes++;
    endtask

    task automatic test_back_to_back();
        int err_before;
        int seeds[3];
        logic [4:0] cls[3];
        logic [4:0] want;
        seeds = '{11, 22, 33};
        cls   = '{5'd6, 5'd19, 5'd30};
        err_before = err_pulses;
        for (int f = 0; f < 3; f++) begin
            tree_class = cls[f];
            exp_q.push_back(cls[f]);
            send_frame(279, seeds[f], 1);
            checks++; if (x27 !== fb(27, seeds[f]) || x278 !== fb(278, seeds[f]))
                $display("FAIL t6_x f%0d got %h %h need %h %h", f, x27, x278, fb(27, seeds[f]), fb(278, seeds[f])); else passes++;
            step();
            want = exp_q.pop_front();
            checks++; if (m_valid !== 1'b1 || m_class !== want) $display("FAIL t6_cls f%0d got mv=%0d cls=%0d need 1 %0d", f, m_valid, m_class, want); else passes++;
            step();
        end
        checks++; if (sample_cnt !== 16'd4) $display("FAIL t6_cnt got %0d need 4", sample_cnt); else passes++;
        checks++; if (err_pulses !== err_before) $display("FAIL t6_no_err got %0d pulses need %0d", err_pulses, err_before); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
